adc_spi_responder: RTL and testbench
====================================

Name: adc_spi_responder

Overview:
- Digital-twin model of the MIKROE-340 (MCP3204-class) ADC: the SPI responder side of the ADC link.
- Oversamples CS, SCLK and MOSI on the 50 MHz FPGA clock and decodes the start and control bits.
- Returns a 12-bit sample on MISO, taken from parallel channel inputs.
- Used to close the loop on the ADC controller in simulation and on-board, and to inject known or faulty codes for circuit-failure studies.

Parameters:
- NUM_CH, 4: number of channels modelled; D2 is don't-care when NUM_CH=4.
- SYNC_STAGES, 2: synchronizer depth on CS, SCLK and MOSI; legal values are 2 or 3.

Ports:
- clk  input  1  50 MHz FPGA clock.
- rst_n  input  1  asynchronous active-low reset.
- cs_n  input  1  chip select from the master; active low.
- sclk  input  1  SPI clock from the master (nominally 50 kHz).
- mosi  input  1  master-out data.
- miso  output  1  responder-out data.
- miso_oe  output  1  high while the responder drives miso; used by the top level for tristate.
- ch_data  input  12*NUM_CH  channel codes; channel k occupies [12k+11:12k].
- conv_done  output  1  one-clk pulse after B0 has been driven.
- frame_err  output  1  one-clk pulse when cs_n rises before conv_done.
- last_sgl  output  1  SGL/DIFF bit of the last decoded frame.
- last_ch  output  2  D1:D0 of the last decoded frame.
- last_sample  output  12  code shifted out in the last frame.

Behaviour:
- Reset values: miso=0, miso_oe=0, conv_done=0, frame_err=0, last_sgl=0, last_ch=0, last_sample=0. State is IDLE, and all synchronizer flops are set to the idle bus levels: cs_n=1, sclk=0, mosi=0.
- Inputs pass through SYNC_STAGES flops, then edge detection. A pin edge becomes an internal event SYNC_STAGES+1 clk later.
- sclk high and low times must each be at least 8 clk. Timing below that is out of spec.
- Bus timing: the master changes mosi on sclk falling edges; the responder samples mosi on sclk rising edges. The responder changes miso on sclk falling edges; the master samples miso on rising edges.
- IDLE: miso_oe=0, miso=0. A cs_n falling edge goes to WAIT_START.
- WAIT_START: on each sclk rising edge, if mosi=1, go to CTRL with bit count=0. Leading zeros are ignored.
- CTRL: capture 4 bits on successive rising edges, in order SGL, D2, D1, D0. On the D0 edge, latch the output code:
  - SGL=1: code = channel D1:D0.
  - SGL=0: pairs are 00 -> CH0-CH1, 01 -> CH1-CH0, 10 -> CH2-CH3, 11 -> CH3-CH2. Subtraction is 13-bit; a negative result saturates to 0.
  - Go to SAMPLE.
- SAMPLE: first falling edge: miso_oe=1, miso=0. Go to NULL.
- NULL: next falling edge drives the null bit, miso=0. Go to DATA with index 11.
- DATA: each falling edge drives code[index], B11 first, then decrements index. On the falling edge that drives B0, go to DONE.
- DONE:
  - Entering DONE: pulse conv_done one clk; update last_sgl, last_ch and last_sample.
  - Further falling edges drive miso=0. No LSB-first replay.
  - miso_oe stays 1 until cs_n rises.
- cs_n rising edge in any state: go to IDLE, miso_oe=0 and miso=0 on the same clk. If the state was CTRL, SAMPLE, NULL or DATA, pulse frame_err for one clk. last_* outputs are not updated.
- cs_n rising and an sclk edge detected on the same clk: cs_n wins and the sclk edge is ignored.
- ch_data changing mid-frame has no effect; the code is frozen at D0.
- rst_n asserted mid-frame: immediate return to reset values, and no frame_err.
- sclk edges while cs_n is high are ignored.

Test Plan:
- Single-ended ch0: ch_data ch0=12'hA5C; frame start=1, SGL=1, D2=x, D1=0, D0=0. Required response: miso after the control bits reads 0 (sample), 0 (null), then 1010_0101_1100. conv_done pulses once, last_sample=12'hA5C, last_ch=0.
- Controller cadence: pair with the existing ADC controller timing (CS low for 20 sclk, 50 kHz). Required response: the 12 bits the controller shifts in equal the ch0 code (ch0=12'h800). After DONE, miso stays 0 through the remaining clocks.
- Differential: ch2=12'h300, ch3=12'h100. D1:D0=10 returns 12'h200. D1:D0=11 returns 12'h000, the saturated case.
- Leading zeros and channel select: three zeros before the start bit, then SGL=1, D1:D0=11, ch3=12'hFFF. Required response: 12 ones on miso, last_ch=3.
- Abort: cs_n rises after B7 is driven. Required response: frame_err pulses once, miso_oe=0 within SYNC_STAGES+1 clk, last_sample unchanged. The next full frame decodes correctly.
- Reset mid-DATA: pull rst_n low during B4. Required response: all outputs go to reset values immediately and no frame_err. After release, the first full frame is correct.

Source files
------------

// File: rtl/adc_spi_responder_if.sv
// SPI link between an ADC controller (master) and the ADC model (slave).
interface adc_spi_responder_if;
  logic cs_n;
  logic sclk;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output cs_n, output sclk, output mosi, input miso, input miso_oe);
  modport slave  (input cs_n, input sclk, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/adc_spi_responder.sv
// MCP3204-class ADC digital twin: SPI responder that decodes start/control bits
// on oversampled pins and shifts a 12-bit code, taken from parallel inputs, out on miso.
// SYNC_STAGES must be 2 or 3; NUM_CH may be at most 8 (D2 only matters above 4).
module adc_spi_responder #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  adc_spi_responder_if.slave     spi,
  input  logic [12*NUM_CH-1:0]   ch_data,
  output logic                   conv_done,
  output logic                   frame_err,
  output logic                   last_sgl,
  output logic [1:0]             last_ch,
  output logic [11:0]            last_sample
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WAIT_START = 3'd1;
  localparam logic [2:0] CTRL       = 3'd2;
  localparam logic [2:0] SAMPLE     = 3'd3;
  localparam logic [2:0] NULLB      = 3'd4;
  localparam logic [2:0] DATA       = 3'd5;
  localparam logic [2:0] DONE       = 3'd6;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic cs_prev, sclk_prev;
  logic cs_s, sclk_s, mosi_s;
  logic cs_rise, cs_fall, sclk_rise, sclk_fall;

  logic [2:0]  state;
  logic [1:0]  bit_cnt;
  logic [3:0]  idx;
  logic [2:0]  ctrl_bits;   // {SGL, D2, D1} captured before the D0 edge
  logic [11:0] code;
  logic [1:0]  frame_ch;
  logic [11:0] code_next;
  logic [2:0]  sel;

  // Unused channel slots read as zero so channel indexing never leaves the array.
  logic [11:0] ch_arr [0:7];
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ch
      if (gi < NUM_CH) begin : g_used
        assign ch_arr[gi] = ch_data[12*gi +: 12];
      end else begin : g_unused
        assign ch_arr[gi] = 12'h000;
      end
    end
  endgenerate

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;

  // Synchronize the pins and keep one delayed copy for edge detection; idle bus levels on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
    end
  end

  // Output code selected by the control word, with D0 taken live from the current rising edge.
  always_comb begin
    logic [11:0] a, b;
    logic [12:0] diff;
    sel       = {(NUM_CH > 4) ? ctrl_bits[1] : 1'b0, ctrl_bits[0], mosi_s};
    a         = ch_arr[{sel[2:1], 1'b0}];
    b         = ch_arr[{sel[2:1], 1'b1}];
    diff      = sel[0] ? ({1'b0, b} - {1'b0, a}) : ({1'b0, a} - {1'b0, b});
    code_next = diff[12] ? 12'h000 : diff[11:0];
    if (ctrl_bits[2]) begin
      code_next = ch_arr[sel];
    end
  end

  // Frame state machine; a cs_n rise overrides any sclk edge seen on the same clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      idx         <= '0;
      ctrl_bits   <= '0;
      code        <= '0;
      frame_ch    <= '0;
      spi.miso    <= 1'b0;
      spi.miso_oe <= 1'b0;
      conv_done   <= 1'b0;
      frame_err   <= 1'b0;
      last_sgl    <= 1'b0;
      last_ch     <= '0;
      last_sample <= '0;
    end else begin
      conv_done <= 1'b0;
      frame_err <= 1'b0;
      if (cs_rise) begin
        state       <= IDLE;
        spi.miso    <= 1'b0;
        spi.miso_oe <= 1'b0;
        if (state == CTRL || state == SAMPLE || state == NULLB || state == DATA) begin
          frame_err <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) state <= WAIT_START;
          end
          WAIT_START: begin
            if (sclk_rise && mosi_s) begin
              state   <= CTRL;
              bit_cnt <= '0;
            end
          end
          CTRL: begin
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 2'd1;
              if (bit_cnt == 2'd3) begin
                code     <= code_next;
                frame_ch <= sel[1:0];
                state    <= SAMPLE;
              end else begin
                ctrl_bits <= {ctrl_bits[1:0], mosi_s};
              end
            end
          end
          SAMPLE: begin
            if (sclk_fall) begin
              spi.miso_oe <= 1'b1;
              spi.miso    <= 1'b0;
              state       <= NULLB;
            end
          end
          NULLB: begin
            if (sclk_fall) begin
              spi.miso <= 1'b0;
              idx      <= 4'd11;
              state    <= DATA;
            end
          end
          DATA: begin
            if (sclk_fall) begin
              spi.miso <= code[idx];
              if (idx == 4'd0) begin
                state       <= DONE;
                conv_done   <= 1'b1;
                last_sgl    <= ctrl_bits[2];
                last_ch     <= frame_ch;
                last_sample <= code;
              end else begin
                idx <= idx - 4'd1;
              end
            end
          end
          DONE: begin
            if (sclk_fall) spi.miso <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: drives SPI frames as a master would and
// compares the shifted-in code and status outputs with hand-computed values.
module tb_adc_spi_responder;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] ch_data = '0;
  logic        conv_done, frame_err, last_sgl;
  logic [1:0]  last_ch;
  logic [11:0] last_sample;

  int checks = 0;
  int failures = 0;
  int cd_cnt = 0;
  int fe_cnt = 0;

  adc_spi_responder_if spi_if ();

  adc_spi_responder #(.NUM_CH(4), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi         (spi_if),
    .ch_data     (ch_data),
    .conv_done   (conv_done),
    .frame_err   (frame_err),
    .last_sgl    (last_sgl),
    .last_ch     (last_ch),
    .last_sample (last_sample)
  );

  always #10 clk = ~clk;

  // Pulse counters: one count per clk the pulse is high.
  always @(posedge clk) begin
    if (conv_done) cd_cnt <= cd_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic set_ch(input int k, input logic [11:0] v);
    ch_data[12*k +: 12] = v;
  endtask

  // One master frame: lz leading zeros, start bit, ctrl={SGL,D2,D1,D0}, then zeros.
  // extra = {sample bit, null bit, bit after B0}.
  task automatic spi_frame(input int lz, input logic [3:0] ctrl, input int nclk, input int half,
                           input bit raise_cs, output logic [11:0] data, output logic [2:0] extra,
                           output logic oe_mid, output logic oe_after);
    logic [63:0] bits;
    bits = '0;
    oe_mid = 1'b0;
    oe_after = 1'bx;
    @(negedge clk);
    spi_if.cs_n = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nclk; i++) begin
      if (i == lz) spi_if.mosi = 1'b1;
      else if (i > lz && i <= lz + 4) spi_if.mosi = ctrl[3 - (i - lz - 1)];
      else spi_if.mosi = 1'b0;
      repeat (half) @(negedge clk);
      spi_if.sclk = 1'b1;
      bits[i] = spi_if.miso;
      if (i == nclk - 1) oe_mid = spi_if.miso_oe;
      repeat (half) @(negedge clk);
      spi_if.sclk = 1'b0;
    end
    spi_if.mosi = 1'b0;
    repeat (half) @(negedge clk);
    for (int k = 0; k < 12; k++) data[11 - k] = bits[lz + 7 + k];
    extra = {bits[lz + 5], bits[lz + 6], bits[lz + 19]};
    if (raise_cs) begin
      spi_if.cs_n = 1'b1;
      repeat (SS + 1) @(posedge clk);
      #1 oe_after = spi_if.miso_oe;
      repeat (10) @(negedge clk);
    end
  endtask

  logic [11:0] data;
  logic [2:0]  extra;
  logic        oe_mid, oe_after;
  int          cd0, fe0;

  initial begin
    spi_if.cs_n = 1'b1;
    spi_if.sclk = 1'b0;
    spi_if.mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", spi_if.miso, 0);
    check("rst_miso_oe", spi_if.miso_oe, 0);
    check("rst_conv_done", conv_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_last", {last_sgl, last_ch, last_sample}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single-ended ch0
    set_ch(0, 12'hA5C);
    cd0 = cd_cnt; fe0 = fe_cnt;
    spi_frame(0, 4'b1000, 20, 10, 1'b1, data, extra, oe_mid, oe_after);
    check("se0_data", data, 12'hA5C);
    check("se0_sample_null_tail", extra, 3'b000);
    check("se0_conv_done", cd_cnt - cd0, 1);
    check("se0_frame_err", fe_cnt - fe0, 0);
    check("se0_last_sample", last_sample, 12'hA5C);
    check("se0_last_ch", last_ch, 0);
    check("se0_last_sgl", last_sgl, 1);
    check("se0_oe_mid", oe_mid, 1);
    check("se0_oe_after", oe_after, 0);

    // Controller cadence: 50 kHz sclk, 20 clocks with CS low
    set_ch(0, 12'h800);
    spi_frame(0, 4'b1000, 20, 500, 1'b1, data, extra, oe_mid, oe_after);
    check("ctl_data", data, 12'h800);
    check("ctl_tail_zero", extra, 3'b000);

    // Differential pairs
    set_ch(2, 12'h300);
    set_ch(3, 12'h100);
    spi_frame(0, 4'b0010, 20, 10, 1'b1, data, extra, oe_mid, oe_after);
    check("diff10_data", data, 12'h200);
    check("diff10_last_sgl", last_sgl, 0);
    check("diff10_last_ch", last_ch, 2);
    spi_frame(0, 4'b0011, 20, 10, 1'b1, data, extra, oe_mid, oe_after);
    check("diff11_sat_data", data, 12'h000);
    check("diff11_last_sample", last_sample, 12'h000);

    // Leading zeros, ch3 single-ended
    set_ch(3, 12'hFFF);
    spi_frame(3, 4'b1011, 23, 10, 1'b1, data, extra, oe_mid, oe_after);
    check("lz_data", data, 12'hFFF);
    check("lz_sample_null_tail", extra, 3'b000);
    check("lz_last_ch", last_ch, 3);

    // Abort after B7 driven
    cd0 = cd_cnt; fe0 = fe_cnt;
    spi_frame(0, 4'b1000, 12, 10, 1'b1, data, extra, oe_mid, oe_after);
    check("abort_oe_mid", oe_mid, 1);
    check("abort_oe_after", oe_after, 0);
    check("abort_frame_err", fe_cnt - fe0, 1);
    check("abort_conv_done", cd_cnt - cd0, 0);
    check("abort_last_sample", last_sample, 12'hFFF);
    set_ch(1, 12'h123);
    spi_frame(0, 4'b1001, 20, 10, 1'b1, data, extra, oe_mid, oe_after);
    check("post_abort_data", data, 12'h123);
    check("post_abort_last_ch", last_ch, 1);

    // Reset during B4 of a ch2 frame
    fe0 = fe_cnt;
    spi_frame(0, 4'b1010, 15, 10, 1'b0, data, extra, oe_mid, oe_after);
    check("rstmid_oe_before", spi_if.miso_oe, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_miso_oe", spi_if.miso_oe, 0);
    check("rstmid_miso", spi_if.miso, 0);
    check("rstmid_last", {last_sgl, last_ch, last_sample}, 0);
    spi_if.cs_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rstmid_frame_err", fe_cnt - fe0, 0);
    spi_frame(0, 4'b1010, 20, 10, 1'b1, data, extra, oe_mid, oe_after);
    check("post_rst_data", data, 12'h300);
    check("post_rst_last_sample", last_sample, 12'h300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
